// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: count width helper,
// flag reset values and a parameter legality check.
package fifo_pkg;

  localparam logic RST_FULL      = 1'b0;
  localparam logic RST_EMPTY     = 1'b1;
  localparam logic RST_AFULL     = 1'b0;
  localparam logic RST_AEMPTY    = 1'b1;
  localparam logic RST_DVLD      = 1'b0;
  localparam logic RST_OVERFLOW  = 1'b0;
  localparam logic RST_UNDERFLOW = 1'b0;

  // Occupancy counter width: must hold 0..depth inclusive
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // True when the parameter set is legal for fifo_sync_ctrl
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned depth,
                                   input int unsigned afval,
                                   input int unsigned aeval);
    return (width >= 1) && (width <= 256) &&
           (depth >= 4) && (depth <= 4096) &&
           ((depth & (depth - 1)) == 0) &&
           (aeval >= 1) && (aeval < afval) && (afval < depth);
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// WIDTH x DEPTH simple dual-port storage. Write port is registered.
// Read port: registered with reset (default) or asynchronous when
// FIFO_SYNC_FWFT_EN is defined.
module fifo_sync_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
`ifndef FIFO_SYNC_FWFT_EN
  input  logic                     rst,
  input  logic                     re,
`endif
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word visible combinationally at the read address
  assign rdata = mem[raddr];
`else
  // Output register loads only on a pop, otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, status flags,
// overflow/underflow pulses and data-valid strobe around fifo_sync_ram.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through output behaviour;
// default is one-cycle registered read latency with pulsed DVLD.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AFVAL = 508,
  parameter int unsigned AEVAL = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WE,
  input  logic [WIDTH-1:0]         DATA,
  input  logic                     RE,
  output logic [WIDTH-1:0]         Q,
  output logic                     DVLD,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     AFULL,
  output logic                     AEMPTY,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  output logic [cnt_w(DEPTH)-1:0]  COUNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  // Reject illegal parameter sets at elaboration
  if (!params_ok(WIDTH, DEPTH, AFVAL, AEVAL)) begin : g_param_check
    $error("fifo_sync_ctrl: illegal WIDTH/DEPTH/AFVAL/AEVAL combination");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_accept_c;
  logic             rd_accept_c;
  logic [CW-1:0]    count_nxt_c;
  logic [WIDTH-1:0] ram_rdata;

  // Acceptance is gated by the registered flags only
  assign wr_accept_c = WE & ~FULL;
  assign rd_accept_c = RE & ~EMPTY;

  // Next occupancy: unchanged when both or neither side is accepted
  always_comb begin
    count_nxt_c = COUNT;
    if (wr_accept_c && !rd_accept_c)      count_nxt_c = COUNT + CW'(1);
    else if (!wr_accept_c && rd_accept_c) count_nxt_c = COUNT - CW'(1);
  end

  // Pointers, count, flags from next count, and error pulses
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      COUNT     <= '0;
      FULL      <= RST_FULL;
      EMPTY     <= RST_EMPTY;
      AFULL     <= RST_AFULL;
      AEMPTY    <= RST_AEMPTY;
      OVERFLOW  <= RST_OVERFLOW;
      UNDERFLOW <= RST_UNDERFLOW;
    end else begin
      if (wr_accept_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_accept_c) rd_ptr <= rd_ptr + AW'(1);
      COUNT     <= count_nxt_c;
      FULL      <= (count_nxt_c == CW'(DEPTH));
      EMPTY     <= (count_nxt_c == CW'(0));
      AFULL     <= (count_nxt_c >= CW'(AFVAL));
      AEMPTY    <= (count_nxt_c <= CW'(AEVAL));
      OVERFLOW  <= WE & FULL;
      UNDERFLOW <= RE & EMPTY;
    end
  end

  fifo_sync_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (CLK),
`ifndef FIFO_SYNC_FWFT_EN
    .rst   (RESET),
    .re    (rd_accept_c),
`endif
    .we    (wr_accept_c),
    .waddr (wr_ptr),
    .wdata (DATA),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

`ifdef FIFO_SYNC_FWFT_EN
  // Head word shown whenever non-empty; zero while empty
  assign Q    = EMPTY ? '0 : ram_rdata;
  assign DVLD = ~EMPTY;
`else
  assign Q = ram_rdata;

  // Valid strobe for the cycle after each accepted pop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) DVLD <= RST_DVLD;
    else       DVLD <= rd_accept_c;
  end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Self-checking bench for fifo_sync_ctrl: queue-based reference model,
// per-cycle compare process, directed boundary cases and a random wrap run.
module tb_fifo_sync_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 512;
  localparam int unsigned AF = 508;
  localparam int unsigned AE = 4;
  localparam int unsigned CW = $clog2(D) + 1;

  logic          CLK   = 1'b0;
  logic          RESET = 1'b1;
  logic          WE    = 1'b0;
  logic          RE    = 1'b0;
  logic [W-1:0]  DATA  = '0;
  logic [W-1:0]  Q;
  logic          DVLD, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
  logic [CW-1:0] COUNT;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_q   = '0;
  logic         m_dvld = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         m_unf  = 1'b0;
  int           pops   = 0;

  fifo_sync_ctrl #(
    .WIDTH (W),
    .DEPTH (D),
    .AFVAL (AF),
    .AEVAL (AE)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .WE        (WE),
    .DATA      (DATA),
    .RE        (RE),
    .Q         (Q),
    .DVLD      (DVLD),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .AFULL     (AFULL),
    .AEMPTY    (AEMPTY),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW),
    .COUNT     (COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a queue with the accept/drop rules applied per edge
  always @(posedge CLK or posedge RESET) begin : model
    bit full_now;
    bit empty_now;
    if (RESET) begin
      mq.delete();
      m_q    = '0;
      m_dvld = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      full_now  = (mq.size() == D);
      empty_now = (mq.size() == 0);
      m_ovf  = WE && full_now;
      m_unf  = RE && empty_now;
      m_dvld = 1'b0;
      if (RE && !empty_now) begin
        m_q    = mq.pop_front();
        m_dvld = 1'b1;
        pops++;
      end
      if (WE && !full_now) mq.push_back(DATA);
    end
  end

  // Compare all outputs against the model every cycle
  always @(negedge CLK) begin : compare
    int n;
    n = mq.size();
    chk("count",     64'(COUNT),     64'(n));
    chk("count_max", 64'(COUNT > CW'(D)), 64'h0);
    chk("full",      64'(FULL),      64'(n == D));
    chk("empty",     64'(EMPTY),     64'(n == 0));
    chk("afull",     64'(AFULL),     64'(n >= AF));
    chk("aempty",    64'(AEMPTY),    64'(n <= AE));
    chk("overflow",  64'(OVERFLOW),  64'(m_ovf));
    chk("underflow", 64'(UNDERFLOW), 64'(m_unf));
`ifdef FIFO_SYNC_FWFT_EN
    chk("dvld", 64'(DVLD), 64'(n != 0));
    if (n != 0) chk("q", 64'(Q), 64'(mq[0]));
    else        chk("q", 64'(Q), 64'h0);
`else
    chk("dvld", 64'(DVLD), 64'(m_dvld));
    chk("q",    64'(Q),    64'(m_q));
`endif
  end

  task automatic cyc(input logic we, input logic [W-1:0] d, input logic re);
    @(negedge CLK);
    WE = we; DATA = d; RE = re;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"},  64'(COUNT),     64'h0);
    chk({tag, "_empty"},  64'(EMPTY),     64'h1);
    chk({tag, "_aempty"}, 64'(AEMPTY),    64'h1);
    chk({tag, "_full"},   64'(FULL),      64'h0);
    chk({tag, "_afull"},  64'(AFULL),     64'h0);
    chk({tag, "_dvld"},   64'(DVLD),      64'h0);
    chk({tag, "_ovf"},    64'(OVERFLOW),  64'h0);
    chk({tag, "_unf"},    64'(UNDERFLOW), 64'h0);
    chk({tag, "_q"},      64'(Q),         64'h0);
  endtask

  initial begin
    int          wr_n;
    int          cyc_n;
    int          pops0;
    int unsigned we_pct;
    int unsigned re_pct;
    logic        we_r;
    logic        re_r;

    repeat (3) @(posedge CLK);
    #1;
    chk_reset("por");
    @(negedge CLK);
    RESET = 1'b0;

    // First four writes: count steps, EMPTY falls, AEMPTY stays high
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, W'(32'hA0 + i), 1'b0);
      chk("wr4_count",  64'(COUNT),  64'(i + 1));
      chk("wr4_empty",  64'(EMPTY),  64'h0);
      chk("wr4_aempty", 64'(AEMPTY), 64'h1);
    end

    // Fill to DEPTH, checking threshold crossings
    for (int i = 4; i < D; i++) begin
      cyc(1'b1, W'(32'h1000 + i), 1'b0);
      if (i == 4)      chk("aempty_at5",  64'(AEMPTY), 64'h0);
      if (i == AF - 2) chk("afull_at507", 64'(AFULL),  64'h0);
      if (i == AF - 1) chk("afull_at508", 64'(AFULL),  64'h1);
      if (i == D - 2)  chk("full_at511",  64'(FULL),   64'h0);
    end
    chk("full_at512",  64'(FULL),  64'h1);
    chk("count_512",   64'(COUNT), 64'(D));

    // Write while full: dropped, OVERFLOW pulses
    cyc(1'b1, 32'hDEAD, 1'b0);
    chk("ovf_pulse", 64'(OVERFLOW), 64'h1);
    chk("ovf_count", 64'(COUNT),    64'(D));

    // Write+read while full: write dropped, read accepted
    cyc(1'b1, 32'hBEEF, 1'b1);
    chk("fwr_count", 64'(COUNT),    64'(D - 1));
    chk("fwr_ovf",   64'(OVERFLOW), 64'h1);
    chk("fwr_dvld",  64'(DVLD),     64'h1);
`ifdef FIFO_SYNC_FWFT_EN
    chk("fwr_q",     64'(Q),        64'hA1);
`else
    chk("fwr_q",     64'(Q),        64'hA0);
`endif
    cyc(1'b0, '0, 1'b0);
    chk("ovf_clear", 64'(OVERFLOW), 64'h0);

    // Drain everything back-to-back
    for (int i = 0; i < D - 1; i++) cyc(1'b0, '0, 1'b1);
    chk("drain_empty", 64'(EMPTY), 64'h1);
    chk("drain_count", 64'(COUNT), 64'h0);
`ifndef FIFO_SYNC_FWFT_EN
    chk("drain_lastq", 64'(Q),    64'h11FF);
    chk("drain_dvld",  64'(DVLD), 64'h1);
`endif

    // Read+write while empty: read ignored, UNDERFLOW pulses
    cyc(1'b1, 32'h77, 1'b1);
    chk("unf_pulse", 64'(UNDERFLOW), 64'h1);
    chk("unf_count", 64'(COUNT),     64'h1);
`ifdef FIFO_SYNC_FWFT_EN
    chk("unf_q",     64'(Q),         64'h77);
    chk("unf_dvld",  64'(DVLD),      64'h1);
`else
    chk("unf_q",     64'(Q),         64'h11FF);
    chk("unf_dvld",  64'(DVLD),      64'h0);
`endif
    cyc(1'b0, '0, 1'b1);
    chk("unf_clear", 64'(UNDERFLOW), 64'h0);
`ifndef FIFO_SYNC_FWFT_EN
    chk("unf_popq",  64'(Q),         64'h77);
`endif
    cyc(1'b0, '0, 1'b0);

    // Random concurrent traffic of 1500 incrementing words across pointer wraps
    pops0 = pops;
    wr_n  = 0;
    cyc_n = 0;
    we_pct = 50;
    re_pct = 50;
    while ((wr_n < 1500 || mq.size() != 0) && cyc_n < 20000) begin
      if (cyc_n % 150 == 0) begin
        case ((cyc_n / 150) % 5)
          0:       begin we_pct = 95; re_pct = 15;  end
          1:       begin we_pct = 50; re_pct = 50;  end
          2:       begin we_pct = 20; re_pct = 85;  end
          3:       begin we_pct = 100; re_pct = 100; end
          default: begin we_pct = 70; re_pct = 40;  end
        endcase
      end
      we_r = (wr_n < 1500) && ($urandom_range(99) < we_pct);
      re_r = (wr_n >= 1500) || ($urandom_range(99) < re_pct);
      if (we_r && mq.size() < D) begin
        cyc(1'b1, W'(wr_n), re_r);
        wr_n++;
      end else begin
        cyc(we_r, W'(wr_n), re_r);
      end
      cyc_n++;
    end
    chk("wrap_budget", 64'(cyc_n < 20000), 64'h1);
    chk("wrap_pops",   64'(pops - pops0),  64'd1500);
    chk("wrap_empty",  64'(EMPTY),         64'h1);
`ifndef FIFO_SYNC_FWFT_EN
    chk("wrap_lastq",  64'(Q),             64'd1499);
`endif

    // Asynchronous reset with 300 words stored
    for (int i = 0; i < 300; i++) cyc(1'b1, W'(32'h2000 + i), 1'b0);
    chk("pre_rst_count", 64'(COUNT), 64'd300);
    @(negedge CLK);
    WE = 1'b0; RE = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    chk_reset("async");
    @(posedge CLK);
    #1;
    @(negedge CLK);
    RESET = 1'b0;

    // First write after reset is the next word read
    cyc(1'b1, 32'h55, 1'b0);
    chk("post_rst_count", 64'(COUNT), 64'h1);
`ifdef FIFO_SYNC_FWFT_EN
    chk("post_rst_q",     64'(Q),     64'h55);
`endif
    cyc(1'b0, '0, 1'b1);
    chk("post_rst_dvld",  64'(DVLD),  64'(`ifdef FIFO_SYNC_FWFT_EN 0 `else 1 `endif));
`ifndef FIFO_SYNC_FWFT_EN
    chk("post_rst_q",     64'(Q),     64'h55);
`endif
    cyc(1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
